// File: rtl/alu_share_ctrl.sv
// -----------------------------------------------------------------------------
// alu_share_ctrl
//
// Shares one combinational ALU (add/sub/mul/div, 3-bit operands, 8-bit result)
// between two requesters. Requests are granted round-robin, the chosen
// operation is held on the ALU inputs for a per-opcode number of execute
// cycles, the ALU result is captured, and it is returned to the owning
// requester over a valid/ready response channel.
//
// Parameters:
//   MUL_CYCLES  execute cycles for op 2'b10 (1..15)
//   DIV_CYCLES  execute cycles for op 2'b11 (1..15)
//
// Ports:
//   clk, rst            clock (rising edge), asynchronous active-high reset
//   req_valid[1:0]      per-requester request valid
//   req_ready[1:0]      per-requester request accept (one-hot or zero)
//   req_op0/1, req_a0/1, req_b0/1   request opcode and operands
//   rsp_valid[1:0]      response valid to the owning requester
//   rsp_ready[1:0]      per-requester response accept
//   rsp_data[7:0]       captured result, qualified by rsp_valid
//   alu_op, alu_a, alu_b  drive the shared ALU
//   alu_result[7:0]     combinational ALU output
//   busy                high while an operation is executing or responding
// -----------------------------------------------------------------------------
module alu_share_ctrl #(
    parameter int MUL_CYCLES = 2,
    parameter int DIV_CYCLES = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req_valid,
    output logic [1:0] req_ready,
    input  logic [1:0] req_op0,
    input  logic [1:0] req_op1,
    input  logic [2:0] req_a0,
    input  logic [2:0] req_a1,
    input  logic [2:0] req_b0,
    input  logic [2:0] req_b1,
    output logic [1:0] rsp_valid,
    input  logic [1:0] rsp_ready,
    output logic [7:0] rsp_data,
    output logic [1:0] alu_op,
    output logic [2:0] alu_a,
    output logic [2:0] alu_b,
    input  logic [7:0] alu_result,
    output logic       busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic [3:0] MUL_CNT = 4'(MUL_CYCLES);
    localparam logic [3:0] DIV_CNT = 4'(DIV_CYCLES);

    state_t     state;
    logic       ptr;       // requester that wins when both are valid
    logic       owner;     // requester being served
    logic [1:0] op_r;
    logic [2:0] a_r;
    logic [2:0] b_r;
    logic [3:0] cnt;       // remaining execute cycles, including the current one
    logic [7:0] result;

    logic [1:0] grant;
    logic       grant_id;
    logic [1:0] sel_op;
    logic [2:0] sel_a;
    logic [2:0] sel_b;

    // Grant decode. Gated by rst so req_ready reads zero while reset is held,
    // even if requesters are already asserting valid.
    // NOTE: every signal assigned in always_comb gets a default first so no
    // path leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        grant    = 2'b00;
        grant_id = ptr;
        if (state == IDLE && !rst) begin
            case (req_valid)
                2'b01: begin grant = 2'b01; grant_id = 1'b0; end
                2'b10: begin grant = 2'b10; grant_id = 1'b1; end
                2'b11: begin grant = ptr ? 2'b10 : 2'b01; grant_id = ptr; end
                default: ;
            endcase
        end
    end

    assign sel_op = grant_id ? req_op1 : req_op0;
    assign sel_a  = grant_id ? req_a1  : req_a0;
    assign sel_b  = grant_id ? req_b1  : req_b0;

    function automatic logic [3:0] exec_cycles(input logic [1:0] op);
        case (op)
            2'b10:   return MUL_CNT;
            2'b11:   return DIV_CNT;
            default: return 4'd1;
        endcase
    endfunction

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    // NOTE: the datapath registers are reset as well because they drive
    // alu_*/rsp_data directly and those outputs must read zero after reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            ptr    <= 1'b0;
            owner  <= 1'b0;
            op_r   <= 2'b00;
            a_r    <= 3'b000;
            b_r    <= 3'b000;
            cnt    <= 4'd0;
            result <= 8'h00;
        end else begin
            case (state)
                IDLE: begin
                    if ((req_valid & grant) != 2'b00) begin
                        op_r  <= sel_op;
                        a_r   <= sel_a;
                        b_r   <= sel_b;
                        owner <= grant_id;
                        ptr   <= ~grant_id;
                        cnt   <= exec_cycles(sel_op);
                        state <= EXEC;
                    end
                end
                EXEC: begin
                    cnt <= cnt - 4'd1;
                    if (cnt == 4'd1) begin
                        result <= alu_result;
                        state  <= RESP;
                    end
                end
                RESP: begin
                    // Only the owner's rsp_ready matters; no accept happens
                    // in this cycle because req_ready is zero outside IDLE.
                    if (rsp_ready[owner]) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign req_ready = grant;
    assign rsp_valid = (state == RESP) ? (owner ? 2'b10 : 2'b01) : 2'b00;
    assign rsp_data  = result;
    assign alu_op    = op_r;
    assign alu_a     = a_r;
    assign alu_b     = b_r;
    assign busy      = (state != IDLE);

endmodule

// File: tb/tb_alu_share_ctrl.sv
// -----------------------------------------------------------------------------
// tb_alu_share_ctrl
//
// Directed bench for alu_share_ctrl. The bench plays the role of the shared
// ALU with a small behavioural model; all expected results are hand-computed
// constants in the vector table and the hand-written sequences.
// -----------------------------------------------------------------------------
module tb_alu_share_ctrl;

    logic       clk;
    logic       rst;
    logic [1:0] req_valid;
    logic [1:0] req_ready;
    logic [1:0] req_op0, req_op1;
    logic [2:0] req_a0, req_a1, req_b0, req_b1;
    logic [1:0] rsp_valid;
    logic [1:0] rsp_ready;
    logic [7:0] rsp_data;
    logic [1:0] alu_op;
    logic [2:0] alu_a, alu_b;
    logic [7:0] alu_result;
    logic       busy;

    int checks = 0;
    int errors = 0;

    alu_share_ctrl #(.MUL_CYCLES(2), .DIV_CYCLES(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_op0    (req_op0),
        .req_op1    (req_op1),
        .req_a0     (req_a0),
        .req_a1     (req_a1),
        .req_b0     (req_b0),
        .req_b1     (req_b1),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_data   (rsp_data),
        .alu_op     (alu_op),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_result (alu_result),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural ALU.
    always_comb begin
        alu_result = 8'h00;
        case (alu_op)
            2'b00: alu_result = {5'b0, alu_a} + {5'b0, alu_b};
            2'b01: alu_result = {5'b0, alu_a} - {5'b0, alu_b};
            2'b10: alu_result = {5'b0, alu_a} * {5'b0, alu_b};
            2'b11: alu_result = (alu_b == 3'd0) ? 8'hFF : ({5'b0, alu_a} / {5'b0, alu_b});
            default: ;
        endcase
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got timeout, want completion");
        $fatal(1, "watchdog");
    end

    typedef struct {
        int         who;
        logic [1:0] op;
        logic [2:0] a;
        logic [2:0] b;
        logic [7:0] exp;
        int         lat;
        string      name;
    } vec_t;

    vec_t vecs[6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    task automatic set_req(input int who, input logic [1:0] op, input logic [2:0] a, input logic [2:0] b);
        if (who == 0) begin
            req_op0 = op; req_a0 = a; req_b0 = b;
        end else begin
            req_op1 = op; req_a1 = a; req_b1 = b;
        end
    endtask

    // Present a single request at a negedge, check the grant, let it be
    // accepted on the next edge and drop valid. Returns at the first negedge
    // after the accept edge.
    task automatic start_req(input int who, input logic [1:0] op, input logic [2:0] a,
                             input logic [2:0] b, input string name);
        @(negedge clk);
        set_req(who, op, a, b);
        req_valid[who] = 1'b1;
        #1;
        check({name, " req_ready"}, 32'(req_ready), 32'(2'b01 << who));
        @(posedge clk);
        @(negedge clk);
        req_valid[who] = 1'b0;
    endtask

    // Called at the first negedge after the accept edge. Measures latency,
    // checks the response, optionally stalls it, then completes the handshake.
    task automatic wait_rsp(input int who, input logic [7:0] exp, input int lat,
                            input logic [1:0] op, input logic [2:0] a, input logic [2:0] b,
                            input int stall, input string name);
        int n = 0;
        bit busy_ok = 1'b1;
        bit alu_ok = 1'b1;
        int other = 1 - who;
        while (rsp_valid == 2'b00 && n < 40) begin
            if (!busy) busy_ok = 1'b0;
            if (alu_op != op || alu_a != a || alu_b != b) alu_ok = 1'b0;
            @(negedge clk);
            n++;
        end
        check({name, " latency"}, 32'(n), 32'(lat));
        check({name, " busy during exec"}, 32'(busy_ok), 32'd1);
        check({name, " alu drive"}, 32'(alu_ok), 32'd1);
        check({name, " rsp_valid"}, 32'(rsp_valid), 32'(2'b01 << who));
        check({name, " rsp_data"}, 32'(rsp_data), 32'(exp));
        if (stall > 0) begin
            set_req(other, 2'b00, 3'd1, 3'd1);
            req_valid[other] = 1'b1;
            rsp_ready[other] = 1'b1;
            for (int k = 0; k < stall; k++) begin
                #1;
                check({name, " stall rsp_valid"}, 32'(rsp_valid), 32'(2'b01 << who));
                check({name, " stall rsp_data"}, 32'(rsp_data), 32'(exp));
                check({name, " stall req_ready"}, 32'(req_ready), 32'd0);
                @(negedge clk);
            end
            req_valid[other] = 1'b0;
            rsp_ready[other] = 1'b0;
        end
        rsp_ready[who] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rsp_ready[who] = 1'b0;
        check({name, " busy after handshake"}, 32'(busy), 32'd0);
        check({name, " rsp_valid after handshake"}, 32'(rsp_valid), 32'd0);
    endtask

    task automatic check_outputs_zero(input string name);
        check({name, " req_ready"}, 32'(req_ready), 32'd0);
        check({name, " rsp_valid"}, 32'(rsp_valid), 32'd0);
        check({name, " rsp_data"}, 32'(rsp_data), 32'd0);
        check({name, " alu"}, 32'({alu_op, alu_a, alu_b}), 32'd0);
        check({name, " busy"}, 32'(busy), 32'd0);
    endtask

    initial begin
        int seen;

        vecs[0] = '{0, 2'b00, 3'd5, 3'd3, 8'h08, 1, "add 5+3"};
        vecs[1] = '{0, 2'b01, 3'd1, 3'd6, 8'hFB, 1, "sub 1-6"};
        vecs[2] = '{0, 2'b11, 3'd7, 3'd2, 8'h03, 4, "div 7/2"};
        vecs[3] = '{0, 2'b11, 3'd7, 3'd0, 8'hFF, 4, "div 7/0"};
        vecs[4] = '{1, 2'b10, 3'd3, 3'd5, 8'h0F, 2, "mul 3*5 r1"};
        vecs[5] = '{1, 2'b00, 3'd7, 3'd7, 8'h0E, 1, "add 7+7 r1"};

        // Reset held for 3 cycles with random inputs.
        rst = 1'b1;
        rsp_ready = 2'b00;
        for (int i = 0; i < 3; i++) begin
            req_valid = 2'($urandom);
            rsp_ready = 2'($urandom);
            set_req(0, 2'($urandom), 3'($urandom), 3'($urandom));
            set_req(1, 2'($urandom), 3'($urandom), 3'($urandom));
            @(negedge clk);
            check_outputs_zero("reset");
        end
        req_valid = 2'b00;
        rsp_ready = 2'b00;
        rst = 1'b0;
        @(negedge clk);
        check("idle req_ready", 32'(req_ready), 32'd0);
        check("idle busy", 32'(busy), 32'd0);

        // Contention right after reset: r0 mul 7*7, r1 add 2+2.
        set_req(0, 2'b10, 3'd7, 3'd7);
        set_req(1, 2'b00, 3'd2, 3'd2);
        req_valid = 2'b11;
        #1;
        check("contend first grant", 32'(req_ready), 32'd1);
        @(negedge clk);
        check("contend exec req_ready", 32'(req_ready), 32'd0);
        wait_rsp(0, 8'h31, 2, 2'b10, 3'd7, 3'd7, 0, "contend r0 mul");
        check("contend second grant", 32'(req_ready), 32'd2);
        @(posedge clk);
        @(negedge clk);
        req_valid[1] = 1'b0;
        wait_rsp(1, 8'h04, 1, 2'b00, 3'd2, 3'd2, 0, "contend r1 add");
        check("contend third grant", 32'(req_ready), 32'd1);
        @(posedge clk);
        @(negedge clk);
        req_valid[0] = 1'b0;
        wait_rsp(0, 8'h31, 2, 2'b10, 3'd7, 3'd7, 0, "contend r0 again");

        // Table-driven single transactions.
        for (int i = 0; i < 6; i++) begin
            start_req(vecs[i].who, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].name);
            wait_rsp(vecs[i].who, vecs[i].exp, vecs[i].lat, vecs[i].op, vecs[i].a,
                     vecs[i].b, 0, vecs[i].name);
        end

        // Backpressure: response held 5 cycles while r1 asks and raises its
        // own rsp_ready (ignored), then r1 withdraws before being served.
        start_req(0, 2'b01, 3'd6, 3'd1, "backpressure sub 6-1");
        wait_rsp(0, 8'h05, 1, 2'b01, 3'd6, 3'd1, 5, "backpressure sub 6-1");

        // Reset pulse in the middle of a divide.
        start_req(0, 2'b11, 3'd7, 3'd2, "abort div");
        @(negedge clk);
        rst = 1'b1;
        #1;
        check_outputs_zero("abort during reset");
        @(negedge clk);
        rst = 1'b0;
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (rsp_valid != 2'b00) seen++;
        end
        check("abort no response", 32'(seen), 32'd0);
        check("abort busy", 32'(busy), 32'd0);
        start_req(1, 2'b00, 3'd2, 3'd2, "after abort r1 add");
        wait_rsp(1, 8'h04, 1, 2'b00, 3'd2, 3'd2, 0, "after abort r1 add");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_share_ctrl.md
# alu_share_ctrl

Controller that shares one combinational 3-bit ALU (add/sub/mul/div, 8-bit result) between two requesters. It arbitrates round-robin, sequences each operation for a per-opcode number of execute cycles, captures the ALU result, and returns it over a valid/ready response channel. It sits between requester logic and the ALU instance, and it drives the ALU's opcode and operand inputs.

## Interface
- MUL_CYCLES, 2, execute cycles for op 2'b10; legal 1..15
- DIV_CYCLES, 4, execute cycles for op 2'b11; legal 1..15
- Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous, active-high reset
- req_valid  in  2  per-requester request valid (bit i = requester i)
- req_ready  out  2  per-requester request accept, one-hot or zero
- req_op0 / req_op1  in  2 each  opcode: 00 add, 01 sub, 10 mul, 11 div
- req_a0 / req_a1  in  3 each  operand A
- req_b0 / req_b1  in  3 each  operand B
- rsp_valid  out  2  response valid to owning requester, one-hot or zero
- rsp_ready  in  2  per-requester response accept
- rsp_data  out  8  shared result bus, qualified by rsp_valid
- alu_op  out  2  to ALU opcode
- alu_a, alu_b  out  3 each  to ALU operands
- alu_result  in  8  from ALU, combinational in alu_op/alu_a/alu_b
- busy  out  1  high in EXEC or RESP

## Operation
- FSM states: IDLE, EXEC, RESP. Reset state is IDLE.
- IDLE: grant goes to the valid requester. If both requesters are valid, the requester selected by the priority pointer `ptr` wins. req_ready[grant] = 1; all other bits are 0. req_ready = 00 when no request is valid.
- Accept occurs on any cycle where req_valid[i] & req_ready[i]. On accept:
  - latch the op, A, B, and owner id;
  - load the counter with 1 (add/sub), MUL_CYCLES, or DIV_CYCLES;
  - set ptr = ~owner;
  - go to EXEC.
- EXEC: alu_op/alu_a/alu_b are driven from the latched registers. The counter decrements each cycle. On the cycle the counter equals 1, capture alu_result into the result register and go to RESP.
- RESP: rsp_valid[owner] = 1 and rsp_data = the captured result, both held stable. When rsp_ready[owner] = 1, go to IDLE. There is no new accept in that same cycle.
- The controller does not compute results; it forwards them. The expected ALU contract is:
  - add: zero-extended A+B;
  - sub: (A-B) mod 256;
  - mul: A*B;
  - div: A/B truncated, with B = 0 giving 8'hFF.
- Requesters must hold op/a/b stable while valid is high and not yet accepted. The controller does not check this.
- The rsp_ready of the non-owner is ignored. rsp_ready may be high before rsp_valid rises.
- Outputs alu_op/alu_a/alu_b keep their last latched values while in IDLE and RESP.

## Timing
- Reset (async assert, sync-safe deassert): state = IDLE, ptr = 0. req_ready, rsp_valid, rsp_data, alu_op, alu_a, alu_b, and busy are all 0.
- Latency: if the accept happens at edge E, rsp_valid rises after edge E+L, where L is the execute cycle count for the op. Add and sub take L = 1.
- Minimum request spacing per transaction is L + 2 edges: accept, L execute cycles, then response handshake, then back in IDLE.
- Reset asserted during EXEC or RESP aborts the operation. No response is issued, all outputs return to their reset values, and ptr = 0.
- A requester that drops req_valid before accept is simply not served. No state changes.
- Request and response of the same requester in the same cycle: the response completes, and the new request is accepted no earlier than the next cycle.
- Fairness: with both requesters continuously valid, grants alternate 0,1,0,1 and the first grant goes to 0.

## Test plan
- Reset: hold rst for 3 cycles with random inputs. Required: all outputs are 0. After release with no valid requests, req_ready = 00 and busy = 0.
- Add: requester 0 sends op 00, A = 5, B = 3. Required: rsp_valid = 01 one cycle after accept, rsp_data = 8'h08. Then sub with A = 1, B = 6. Required: 8'hFB.
- Divide with DIV_CYCLES = 4: A = 7, B = 2 gives 8'h03 four cycles after accept. A = 7, B = 0 gives 8'hFF. busy stays high from accept until the response handshake.
- Contention: both requesters valid right after reset. Requester 0 sends mul 7×7; requester 1 sends add 2+2. Required: requester 0 is served first with 8'h31. Requester 1 is served next with 8'h04, even though requester 0 re-requests immediately. Requester 0 is served third.
- Backpressure: hold rsp_ready low for 5 cycles during RESP. Required: rsp_valid and rsp_data stay stable, and req_ready = 00 throughout.
- Mid-operation reset: pulse rst during EXEC of a div. Required: no rsp_valid is ever seen for that request, outputs are 0, and the next request from requester 1 alone is accepted normally.
